// File: rtl/parity_stream_gen_check.sv
// rtl/parity_stream_gen_check.sv - pipelined per-lane parity generator/checker with frame parity and error count
module parity_stream_gen_check #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       odd_mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [DATA_W/LANE_W-1:0]   in_par,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [DATA_W/LANE_W-1:0]   out_par,
    output logic [DATA_W/LANE_W-1:0]   out_err,
    output logic                       out_last,
    output logic                       frame_par,
    input  logic                       err_clr,
    output logic [CNT_W-1:0]           err_cnt
);

    localparam int LANES = DATA_W / LANE_W;

    logic             accept;
    logic             transfer;
    logic [LANES-1:0] lane_par;
    logic [LANES-1:0] lane_err;
    logic             beat_xor;
    logic             acc;
    logic             cnt_max;

    // Ready depends only on the output register state and out_ready, so a
    // draining beat can be replaced in the same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign cnt_max  = &err_cnt;

    always_comb begin
        lane_par = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_par[k] = (^in_data[k*LANE_W +: LANE_W]) ^ odd_mode;
        end
        lane_err = lane_par ^ in_par;
        beat_xor = ^in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_par   <= '0;
            out_err   <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_par   <= lane_par;
            out_err   <= lane_err;
            out_last  <= in_last;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

    // odd_mode enters the frame result once, from the closing beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= 1'b0;
            frame_par <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                frame_par <= acc ^ beat_xor ^ odd_mode;
                acc       <= 1'b0;
            end else begin
                acc       <= acc ^ beat_xor;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (accept && (|lane_err) && !cnt_max) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_stream_gen_check.sv
// tb/tb_parity_stream_gen_check.sv - randomized and directed bench for parity_stream_gen_check
module tb_parity_stream_gen_check;

    localparam int DATA_W = 32;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 2;
    localparam int LANES  = DATA_W / LANE_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              odd_mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [LANES-1:0]  in_par;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LANES-1:0]  out_par;
    logic [LANES-1:0]  out_err;
    logic              out_last;
    logic              frame_par;
    logic              err_clr;
    logic [CNT_W-1:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the output register should hold after each edge.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [LANES-1:0]  m_par;
    logic [LANES-1:0]  m_err;
    logic              m_last;
    logic              m_fpar;
    int                m_cnt;
    int                m_frame_ones;

    parity_stream_gen_check #(
        .DATA_W(DATA_W), .LANE_W(LANE_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .odd_mode(odd_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_par(in_par), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_par(out_par), .out_err(out_err), .out_last(out_last),
        .frame_par(frame_par), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_par = '0; m_err = '0;
        m_last = 0; m_fpar = 0; m_cnt = 0; m_frame_ones = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, out_valid, m_valid);
        chk({tag, ".data"},  out_data,  m_data);
        chk({tag, ".par"},   out_par,   m_par);
        chk({tag, ".err"},   out_err,   m_err);
        chk({tag, ".last"},  out_last,  m_last);
        chk({tag, ".fpar"},  frame_par, m_fpar);
        chk({tag, ".cnt"},   err_cnt,   m_cnt);
    endtask

    // One clock cycle: called and returns at a falling edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [LANES-1:0] p,
                        input logic l, input logic o, input logic r, input logic c,
                        input string tag);
        logic exp_ready, acc_now, xfer_now;
        logic [LANES-1:0] np;
        logic [LANE_W-1:0] lane;
        in_valid = v; in_data = d; in_par = p; in_last = l;
        odd_mode = o; out_ready = r; err_clr = c;
        #1;
        exp_ready = !m_valid || r;
        chk({tag, ".in_ready"}, in_ready, exp_ready);
        acc_now  = v && exp_ready;
        xfer_now = m_valid && r;
        if (acc_now) begin
            for (int k = 0; k < LANES; k++) begin
                lane  = d[k*LANE_W +: LANE_W];
                np[k] = logic'(($countones(lane) + int'(o)) % 2);
            end
            m_data = d; m_par = np; m_err = np ^ p; m_last = l; m_valid = 1;
            if (l) begin
                m_fpar = logic'((m_frame_ones + $countones(d) + int'(o)) % 2);
                m_frame_ones = 0;
            end else begin
                m_frame_ones += $countones(d);
            end
        end else if (xfer_now) begin
            m_valid = 0;
        end
        if (c) m_cnt = 0;
        else if (acc_now && (m_err != 0) && m_cnt < CNT_MAX) m_cnt++;
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    int cnt_seq [5] = '{1, 2, 3, 3, 3};

    initial begin
        reset_n = 0; odd_mode = 0; in_valid = 0; in_data = '0; in_par = '0;
        in_last = 0; out_ready = 0; err_clr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset_n = 1;

        // Single even-mode beat with matching parity.
        step(1, 32'h01020304, 4'b1101, 1, 0, 1, 0, "t1");
        chk("t1.par_const", out_par, 4'b1101);
        chk("t1.fpar_const", frame_par, 1'b1);
        chk("t1.err_const", out_err, 4'b0000);

        // Same beat in odd mode: every lane mismatches.
        step(1, 32'h01020304, 4'b1101, 1, 1, 1, 0, "t2");
        chk("t2.par_const", out_par, 4'b0010);
        chk("t2.err_const", out_err, 4'b1111);
        chk("t2.fpar_const", frame_par, 1'b0);
        chk("t2.cnt_const", err_cnt, 1);

        // Two-beat frame.
        step(1, 32'h01020304, 4'b1101, 0, 0, 1, 0, "t3a");
        step(1, 32'hFF000001, 4'b0001, 1, 0, 1, 0, "t3b");
        chk("t3.fpar_const", frame_par, 1'b0);
        step(1, 32'h00000001, 4'b0001, 1, 0, 1, 0, "t3c");
        chk("t3.acc_cleared", frame_par, 1'b1);

        // Backpressure stall in the middle of a 4-beat stream.
        step(1, 32'hA0A0A0A0, 4'b0000, 0, 0, 1, 0, "t4a");
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hB1B1B1B1, 4'b1111, 0, 0, 0, 0, "t4stall");
            chk("t4.held_data", out_data, 32'hA0A0A0A0);
            chk("t4.held_valid", out_valid, 1'b1);
        end
        step(1, 32'hB1B1B1B1, 4'b1111, 0, 0, 1, 0, "t4b");
        chk("t4.b_data", out_data, 32'hB1B1B1B1);
        step(1, 32'hC2C2C2C2, 4'b1111, 0, 0, 1, 0, "t4c");
        chk("t4.c_data", out_data, 32'hC2C2C2C2);
        step(1, 32'hD3D3D3D3, 4'b0000, 1, 0, 1, 0, "t4d");
        chk("t4.d_data", out_data, 32'hD3D3D3D3);
        step(0, 32'h0, 4'b0000, 0, 0, 1, 0, "t4drain");
        chk("t4.drained", out_valid, 1'b0);

        // Saturation with a 2-bit counter, then clear beating an increment.
        step(0, 32'h0, 4'b0000, 0, 0, 1, 1, "t5clr");
        chk("t5.cleared", err_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h0, 4'b0001, 1, 0, 1, 0, "t5err");
            chk("t5.cnt_seq", err_cnt, cnt_seq[i]);
        end
        step(1, 32'h0, 4'b0001, 1, 0, 1, 1, "t5clr_inc");
        chk("t5.clr_priority", err_cnt, 0);

        // Asynchronous reset mid-frame.
        step(1, 32'h0F0F0F0F, 4'b0000, 0, 0, 1, 0, "t6a");
        step(1, 32'h00000100, 4'b0000, 0, 0, 1, 0, "t6b");
        in_valid = 0;
        #2 reset_n = 0;
        #1;
        model_reset();
        check_outputs("t6rst");
        @(negedge clk);
        reset_n = 1;
        step(1, 32'h00000001, 4'b0001, 1, 0, 1, 0, "t6c");
        chk("t6.fpar_const", frame_par, 1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 3) != 0), DATA_W'($urandom), LANES'($urandom),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 19) == 0),
                 "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
